// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus: TXDATA/STATUS/BAUDDIV
// registers in a 16-byte window, a TX FIFO and a registered serial line.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        we,
  input  logic [3:0]  byteEnable,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [7:0]      fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            overflow;
  logic [15:0]     bauddiv, eff_div;
  logic [15:0]     div_q, div_q_n, cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n;
  logic            pop, push, push_req, ovf_set, ovf_clr;
  logic            full, empty, last_cycle;
  logic [1:0]      offset;
  logic [31:0]     count_ext;
  logic [3:0]      count_sat;
  logic [31:0]     status;
  logic            unused_bits;

  assign offset      = a[3:2];
  assign sel         = (a[31:4] == BASE_ADDR[31:4]);
  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign eff_div     = (bauddiv == 16'd0) ? 16'd1 : bauddiv;
  assign unused_bits = ^{a[1:0], wd[31:16], byteEnable[3:2]};

  // A full FIFO still accepts a store when the engine pops in the same cycle.
  assign push_req = sel && we && (offset == 2'd0) && byteEnable[0];
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && !push;
  assign ovf_clr  = sel && we && (offset == 2'd1) && byteEnable[0] && wd[3];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wd[7:0];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bauddiv <= DEFAULT_DIV;
    end else if (sel && we && (offset == 2'd2)) begin
      if (byteEnable[0]) bauddiv[7:0]  <= wd[7:0];
      if (byteEnable[1]) bauddiv[15:8] <= wd[15:8];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      div_q <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      div_q <= div_q_n;
      tx    <= tx_n;
    end
  end

  // tx is registered from the next-state view so each phase starts on its edge.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    shift_n    = shift;
    div_q_n    = div_q;
    pop        = 1'b0;
    last_cycle = (cnt == div_q - 16'd1);
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          div_q_n = eff_div;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (last_cycle) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (last_cycle) begin
          cnt_n   = '0;
          shift_n = shift >> 1;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (last_cycle) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_comb begin
    count_ext = 32'(count);
    count_sat = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  end

  assign status = {24'd0, count_sat, overflow, empty, full, (state != IDLE)};

  always_comb begin
    rd = '0;
    if (sel) begin
      case (offset)
        2'd1:    rd = status;
        2'd2:    rd = {16'd0, bauddiv};
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: an abstract frame-timeline model predicts FIFO
// acceptance, STATUS and every tx frame, and a line monitor checks each frame.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;

  logic        clk, clr, we, sel, tx;
  logic [3:0]  byteEnable;
  logic [31:0] a, wd, rd;

  mmio_uart_tx dut (
    .clk(clk), .clr(clr), .we(we), .byteEnable(byteEnable),
    .a(a), .wd(wd), .rd(rd), .sel(sel), .tx(tx)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // reference model: pending bytes with their store edge, and the predicted frames
  typedef struct { logic [7:0] data; int div; int start; } frame_t;
  logic [7:0] exp_q[$];
  int         pend_wr[$];
  frame_t     frames_q[$];
  int         next_free, last_start, last_div, m_div;
  logic       m_ovf;

  function automatic void model_reset();
    exp_q.delete();
    pend_wr.delete();
    frames_q.delete();
    next_free  = 0;
    last_start = 0;
    last_div   = 0;
    m_div      = 868;
    m_ovf      = 1'b0;
  endfunction

  // Retire every byte the engine has taken by edge t into a predicted frame.
  function automatic void advance(input int t);
    int p;
    frame_t f;
    while (exp_q.size() > 0) begin
      p = pend_wr[0] + 1;
      if (next_free > p) p = next_free;
      if (p > t) break;
      f.data  = exp_q.pop_front();
      void'(pend_wr.pop_front());
      f.div   = (m_div == 0) ? 1 : m_div;
      f.start = p;
      frames_q.push_back(f);
      last_start = p;
      last_div   = f.div;
      next_free  = p + 10 * f.div + 1;
    end
  endfunction

  function automatic void model_write(input int t, input logic [31:0] addr,
                                      input logic [31:0] data, input logic [3:0] be);
    advance(t);
    if (addr[31:4] != BASE[31:4]) return;
    case (addr[3:2])
      2'd0: if (be[0]) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(data[7:0]);
          pend_wr.push_back(t);
        end else begin
          m_ovf = 1'b1;
        end
      end
      2'd1: if (be[0] && data[3]) m_ovf = 1'b0;
      2'd2: begin
        if (be[0]) m_div = (m_div & 32'hFF00) | int'(data[7:0]);
        if (be[1]) m_div = (m_div & 32'h00FF) | (int'(data[15:8]) << 8);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] exp_status(input int c);
    int   n, sat;
    logic busy;
    advance(c);
    busy = (last_div > 0) && (c >= last_start) && (c < last_start + 10 * last_div);
    n    = exp_q.size();
    sat  = (n > 15) ? 15 : n;
    return {24'd0, 4'(sat), m_ovf, (n == 0), (n == DEPTH), busy};
  endfunction

  // driver tasks
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    a = addr; wd = data; byteEnable = be; we = 1'b1;
    model_write(cyc + 1, addr, data, be);
    @(posedge clk);
    #1;
    we = 1'b0; byteEnable = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    a = addr; we = 1'b0;
    #1 data = rd;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] v;
    bus_read(BASE + 32'h4, v);
    check(tag, v, exp_status(cyc));
  endtask

  task automatic do_reset();
    clr = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      advance(cyc);
      if (exp_q.size() == 0 && frames_q.size() == 0 && cyc >= next_free) begin
        done = 1'b1;
        break;
      end
    end
    check("drain", 32'(done), 32'd1);
  endtask

  // line monitor: every start bit must match the next predicted frame
  initial begin
    frame_t f;
    int     errs, bitpos, k;
    logic   expb, aborted;
    forever begin
      @(negedge clk);
      if (!clr && tx === 1'b0) begin
        advance(cyc);
        if (frames_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          for (k = 0; k < 20000 && tx !== 1'b1; k++) @(negedge clk);
        end else begin
          f       = frames_q.pop_front();
          errs    = 0;
          aborted = 1'b0;
          check("frame_start", 32'(cyc), 32'(f.start));
          for (int i = 0; i < 10 * f.div; i++) begin
            if (i > 0) @(negedge clk);
            if (clr) begin
              aborted = 1'b1;
              break;
            end
            bitpos = i / f.div;
            if (bitpos == 0)      expb = 1'b0;
            else if (bitpos == 9) expb = 1'b1;
            else                  expb = f.data[bitpos-1];
            if (tx !== expb) errs++;
          end
          if (!aborted) check("frame_bits", 32'(errs), 32'd0);
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [31:0] v;
    int          nbusy, r;
    clr = 1'b1; we = 1'b0; byteEnable = 4'd0; a = 32'd0; wd = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // reset state
    bus_read(BASE + 32'h4, v); check("reset_status", v, 32'h0000_0004);
    bus_read(BASE + 32'h8, v); check("reset_bauddiv", v, 32'd868);
    check("reset_tx", 32'(tx), 32'd1);

    // single frame at div 4, busy for exactly 40 cycles
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    bus_write(BASE, 32'h0000_00A5, 4'b0001);
    nbusy = 0;
    for (int i = 0; i < 45; i++) begin
      bus_read(BASE + 32'h4, v);
      check("busy_trace", v, exp_status(cyc));
      if (v[0]) nbusy++;
    end
    check("busy_cycles", 32'(nbusy), 32'd40);
    wait_done(200);

    // overflow: ten back-to-back stores at div 2
    bus_write(BASE + 32'h8, 32'd2, 4'b0011);
    for (int i = 0; i < 10; i++) bus_write(BASE, $urandom, 4'b0001);
    bus_read(BASE + 32'h4, v);
    check("ovf_set", 32'(v[3]), 32'd1);
    check("ovf_full", 32'(v[1]), 32'd1);
    check("ovf_status", v, exp_status(cyc));
    bus_write(BASE + 32'h4, 32'd8, 4'b0001);
    bus_read(BASE + 32'h4, v);
    check("ovf_clear", 32'(v[3]), 32'd0);
    wait_done(1000);

    // divisor change mid-frame only affects the next frame
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    bus_write(BASE, $urandom, 4'b0001);
    bus_write(BASE, $urandom, 4'b0001);
    repeat (10) @(posedge clk);
    bus_write(BASE + 32'h8, 32'd8, 4'b0011);
    wait_done(400);

    // reset in the middle of a frame with bytes queued
    bus_write(BASE + 32'h8, 32'd4, 4'b0011);
    for (int i = 0; i < 4; i++) bus_write(BASE, $urandom, 4'b0001);
    repeat (14) @(posedge clk);
    #1 clr = 1'b1;
    #1 check("tx_on_clr", 32'(tx), 32'd1);
    do_reset();
    bus_read(BASE + 32'h4, v); check("status_after_clr", v, 32'h0000_0004);
    repeat (60) @(negedge clk);
    check_status("idle_after_clr");

    // decode edges and ignored stores
    @(negedge clk);
    a = BASE + 32'h10; wd = 32'h0000_0012; byteEnable = 4'hF; we = 1'b1;
    #1;
    check("outside_sel", 32'(sel), 32'd0);
    check("outside_rd", rd, 32'd0);
    @(posedge clk);
    #1 we = 1'b0; byteEnable = 4'd0;
    bus_write(BASE, 32'h0000_0055, 4'b0010);
    check_status("no_push_lane1");
    bus_read(BASE, v);           check("txdata_reads0", v, 32'd0);
    bus_read(BASE + 32'hC, v);   check("reserved_reads0", v, 32'd0);
    repeat (20) @(negedge clk);

    // randomized traffic against the model
    bus_write(BASE + 32'h8, 32'd2, 4'b0011);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      bus_write(BASE, $urandom, 4'($urandom_range(0, 15)) | ((r < 5) ? 4'd1 : 4'd0));
      else if (r == 6) bus_write(BASE + 32'h8, 32'($urandom_range(0, 3)), 4'b0011);
      else if (r == 7) check_status("rand_status");
      else if (r == 8) bus_write(BASE + 32'h4, 32'($urandom_range(0, 15)), 4'b0001);
      else             repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    check_status("rand_final_status");
    wait_done(5000);
    check_status("end_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter that responds to the core's data-memory bus, the same we/byteEnable/a/wd/rd interface the data memory serves. Software stores bytes to a TXDATA register. The block buffers them in a FIFO and serialises them as 8N1 frames on a single tx line. It sits beside dmem. Top-level logic uses the sel output to choose between this block's rd and dmem's rd.

Parameters:
BASE_ADDR, 32'hFFFF_0000, base of the 16-byte register window; a[3:0] is ignored for decode.
DEPTH, 8, TX FIFO entries; must be a power of 2, at least 2.
DEFAULT_DIV, 16'd868, reset value of BAUDDIV (clk cycles per bit).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
clr  input  1  reset; asynchronous, active-high.
we  input  1  bus write strobe, from MemWriteM.
byteEnable  input  4  write byte lanes; lane i is wd[8i+7:8i].
a  input  32  bus address, from ALUResultM.
wd  input  32  bus write data.
rd  output  32  combinational read data; 0 when sel=0.
sel  output  1  high when a[31:4] == BASE_ADDR[31:4].
tx  output  1  serial line; idles high.

Behaviour:
- Register map, offset a[3:2]:
  - 0 TXDATA: write only; reads as 0.
  - 1 STATUS: read; write for overflow clear only.
  - 2 BAUDDIV: read/write, bits [15:0]; upper bits read 0.
  - 3 reserved: reads 0, writes ignored.
- STATUS bits:
  - [0] busy: FSM not in IDLE.
  - [1] full.
  - [2] empty.
  - [3] overflow: sticky.
  - [7:4] count: FIFO occupancy, saturating at 15.
  - other bits read 0.
- Reads are combinational on a and current state, with no wait states, matching dmem timing.
- Push: asserted on sel & we & offset 0 & byteEnable[0]; pushes wd[7:0].
  - If byteEnable[0]=0, no push.
- Full FIFO: a push is accepted if the FIFO is not full, or if a pop occurs in the same cycle (count unchanged).
  - Otherwise the byte is dropped and overflow is set to 1.
- Overflow clear: a write to STATUS with byteEnable[0]=1 and wd[3]=1 clears overflow.
  - If a clear and a new overflow occur in the same cycle, overflow stays set.
- BAUDDIV write: byte lanes 0 and 1 update bits [7:0] and [15:8] respectively.
  - A value of 0 is treated as 1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is not empty, on the edge: pop the head into the shift register, latch the effective divisor into div_q, clear the bit counter, go to START.
  - START: tx=0 for div_q cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for div_q cycles, then shift right and increment the index. After index 7 completes, go to STOP. Order is LSB first.
  - STOP: tx=1 for div_q cycles, then go to IDLE.
- Frame timing:
  - Frame length is exactly 10*div_q cycles.
  - IDLE lasts 1 cycle between back-to-back frames, so the idle-high gap is 1 extra cycle.
  - Write-to-start latency: a store at edge N into an empty idle block gives tx=0 after edge N+1.
- Divisor latching: BAUDDIV changes take effect only at the next frame start; the current frame keeps div_q.
- tx is driven from a register (no combinational glitches).
- Reset: while clr=1, and immediately on assertion:
  - tx=1, FSM to IDLE.
  - FIFO emptied (count=0, pointers 0), overflow=0.
  - BAUDDIV=DEFAULT_DIV, shift register and counters 0.
  - A frame in progress is aborted without completion.
- rd/sel: purely decode-driven; they have no reset dependence beyond the register contents.

Test Plan:
- Reset, then read STATUS → rd=32'h0000_0004 (empty); read BAUDDIV → 868; tx=1.
- Write BAUDDIV=4, store 8'hA5 to TXDATA → tx=0 one cycle after the store edge, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1; busy=1 throughout; total frame 40 cycles.
- With BAUDDIV=2, store 10 bytes back to back while the first frame is sending → first 9 accepted (1 popped + 8 buffered), 10th dropped, STATUS[3]=1, STATUS[1]=1; then write STATUS wd=8 → overflow=0.
- Write BAUDDIV=8 mid-frame at div 4 → current frame stays 40 cycles; next frame is 80 cycles.
- Assert clr at bit 3 of a frame with 3 bytes queued → tx=1 immediately, STATUS=4 after release, no further frames.
- Access a=BASE_ADDR+16 with we=1 → sel=0, rd=0, no state change; store with byteEnable=4'b0010 to TXDATA → no push.
